// File: rtl/bcd_pkg.sv
// Constants shared by the BCD <-> binary dabble converters: FSM encoding,
// nibble geometry and digit-correction thresholds.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int BCD_NIBBLE_W = 4;

  localparam logic [BCD_NIBBLE_W-1:0] BCD_MAX_DIGIT = 4'd9;
  // Reverse dabble corrects after a right shift: digits >= 8 lose 3.
  localparam logic [BCD_NIBBLE_W-1:0] ADJ_THRESH    = 4'd8;
  localparam logic [BCD_NIBBLE_W-1:0] ADJ_SUB       = 4'd3;

  function automatic logic nibble_invalid(input logic [BCD_NIBBLE_W-1:0] d);
    return d > BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One-digit reverse-dabble correction: a nibble that reached 8 or more after
// the right shift came from an odd tens carry and is pulled back by 3.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] d_i,
  output logic [BCD_NIBBLE_W-1:0] d_o
);

  assign d_o = (d_i >= ADJ_THRESH) ? (d_i - ADJ_SUB) : d_i;

endmodule

// File: rtl/bcd2binary_reverse_dabble.sv
// Sequential packed-BCD to binary converter (shift-right / subtract-3),
// one operand at a time with valid/ready on both sides.
module bcd2binary_reverse_dabble
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BCD_NIBBLE_W*DIGITS-1:0] in_bcd,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BIN_W-1:0]             out_binary,
  output logic                         out_err
);

  localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  // The largest decimal operand must fit in the binary result.
  if ((10 ** DIGITS) > (2 ** BIN_W)) begin : g_bad_width
    $fatal(1, "BIN_W too narrow to hold 10**DIGITS-1");
  end

  state_e             state_q;
  logic [BCD_W-1:0]   bcd_q, bcd_sh, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIN_W-1:0]   binary_q;
  logic               err_q;
  logic               bad_digit;

  assign {bcd_sh, bin_d} = {bcd_q, bin_q} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_i (bcd_sh[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .d_o (bcd_d[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (nibble_invalid(in_bcd[i*BCD_NIBBLE_W +: BCD_NIBBLE_W])) bad_digit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      binary_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            bcd_q <= in_bcd;
            bin_q <= '0;
            if (bad_digit) begin
              binary_q <= '0;
              err_q    <= 1'b1;
              state_q  <= DONE;
            end else begin
              err_q   <= 1'b0;
              cnt_q   <= '0;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            binary_q <= bin_d;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_binary = binary_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_bcd2binary_reverse_dabble.sv
// Bench for bcd2binary_reverse_dabble: vector table, full decimal sweep,
// random operands against a decimal reference model, and handshake corners.
module tb_bcd2binary_reverse_dabble;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
  localparam int BCD_W  = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [BCD_W-1:0] in_bcd;
  logic             out_valid;
  logic             out_ready;
  logic [BIN_W-1:0] out_binary;
  logic             out_err;

  int errors = 0;
  int checks = 0;

  bcd2binary_reverse_dabble #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bcd     (in_bcd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_binary (out_binary),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  typedef struct {
    logic [BCD_W-1:0] bcd;
    int               exp_bin;
    logic             exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Decimal meaning of a packed BCD word; any nibble above 9 flags an error.
  function automatic void ref_conv(input logic [BCD_W-1:0] bcd, output int val, output logic err);
    int d;
    val = 0;
    err = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(bcd[i*4 +: 4]);
      if (d > 9) err = 1'b1;
      val = val * 10 + d;
    end
    if (err) val = 0;
  endfunction

  function automatic logic [BCD_W-1:0] dec2bcd(input int v);
    logic [BCD_W-1:0] r;
    int               x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Sends one operand (out_ready must be 1) and reports result and edge count
  // from the accept edge (inclusive) to the first cycle with out_valid.
  task automatic do_conv(input logic [BCD_W-1:0] bcd, output logic [BIN_W-1:0] b,
                         output logic e, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    in_bcd   = bcd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_bcd   = BCD_W'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
    b = out_binary;
    e = out_err;
  endtask

  vec_t             vecs[$];
  logic [BIN_W-1:0] got_b;
  logic             got_e;
  int               lat;
  int               ref_v;
  logic             ref_e;
  logic [BCD_W-1:0] op;
  int               n;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bcd    = '0;
    out_ready = 1'b1;

    vecs.push_back('{12'h255, 255, 1'b0});
    vecs.push_back('{12'h000,   0, 1'b0});
    vecs.push_back('{12'h999, 999, 1'b0});
    vecs.push_back('{12'h001,   1, 1'b0});
    vecs.push_back('{12'h100, 100, 1'b0});
    vecs.push_back('{12'h809, 809, 1'b0});
    vecs.push_back('{12'h1A3,   0, 1'b1});
    vecs.push_back('{12'h042,  42, 1'b0});
    vecs.push_back('{12'hF00,   0, 1'b1});
    vecs.push_back('{12'h00F,   0, 1'b1});
    vecs.push_back('{12'h512, 512, 1'b0});

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready",   {31'd0, in_ready},  32'd1);
    chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("rst_out_binary", {22'd0, out_binary}, 32'd0);
    chk("rst_out_err",    {31'd0, out_err},   32'd0);

    // Vector table, including latency and invalid-digit cases
    foreach (vecs[i]) begin
      do_conv(vecs[i].bcd, got_b, got_e, lat);
      chk($sformatf("vec%0d_bin", i), {22'd0, got_b}, 32'(vecs[i].exp_bin));
      chk($sformatf("vec%0d_err", i), {31'd0, got_e}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_lat", i), 32'(lat), vecs[i].exp_err ? 32'd1 : 32'(BIN_W + 1));
    end

    // Full decimal sweep
    for (int v = 0; v < 1000; v++) begin
      do_conv(dec2bcd(v), got_b, got_e, lat);
      chk($sformatf("sweep%0d", v), {22'd0, got_b}, 32'(v));
    end

    // Random operands, valid and invalid mixed
    for (int k = 0; k < 200; k++) begin
      op = (k % 2 == 0) ? dec2bcd(int'($urandom_range(999, 0))) : BCD_W'($urandom);
      ref_conv(op, ref_v, ref_e);
      do_conv(op, got_b, got_e, lat);
      chk($sformatf("rand%0d_bin", k), {22'd0, got_b}, 32'(ref_v));
      chk($sformatf("rand%0d_err", k), {31'd0, got_e}, {31'd0, ref_e});
    end

    // Backpressure: result held while out_ready is low
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bcd    = 12'h999;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_bcd   = 12'h123;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("bp%0d_hold", c),
          {20'd0, in_ready, out_valid, out_binary}, {20'd0, 1'b0, 1'b1, 10'd999});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("bp_in_ready_during_handshake", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("bp_in_ready_after",  {31'd0, in_ready},  32'd1);
    chk("bp_out_valid_after", {31'd0, out_valid}, 32'd0);
    chk("bp_binary_kept",     {22'd0, out_binary}, 32'd999);

    // Reset in the middle of a conversion
    in_valid = 1'b1;
    in_bcd   = 12'h500;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("midrst_binary",    {22'd0, out_binary}, 32'd0);
    n = 0;
    for (int c = 0; c < 15; c++) begin
      if (out_valid) n++;
      @(posedge clk); #1;
    end
    chk("midrst_no_output", 32'(n), 32'd0);
    do_conv(12'h007, got_b, got_e, lat);
    chk("midrst_next_bin", {22'd0, got_b}, 32'd7);
    chk("midrst_next_err", {31'd0, got_e}, 32'd0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd2binary_reverse_dabble.md
Name: bcd2binary_reverse_dabble

Overview:
Sequential packed-BCD to binary converter using the reverse double-dabble (shift-right / subtract-3) algorithm. It is the inverse of the team's binary2bcd_double_dabble block. It is used wherever decimal-entered or displayed values must return to binary, for example a keypad or 7-segment path feeding arithmetic. It processes one operand at a time, with a valid/ready handshake on both sides, and takes BIN_W shift cycles per conversion.

Parameters:
DIGITS, 3, number of packed BCD digits on input (4 bits each).
BIN_W, 10, binary output width. Must satisfy 10^DIGITS - 1 < 2^BIN_W. Elaboration fails otherwise.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_bcd holds an operand.
in_ready  output  1  block can accept an operand.
in_bcd  input  4*DIGITS  packed BCD operand; digit 0 is in bits [3:0].
out_valid  output  1  out_binary and out_err are valid.
out_ready  input  1  consumer accepts the result.
out_binary  output  BIN_W  converted value.
out_err  output  1  operand contained a nibble greater than 9.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state goes to IDLE.
  - in_ready=1, out_valid=0, out_binary=0, out_err=0.
  - Shift register and counter are cleared.
  - Reset mid-conversion aborts it with no output.
- Working register: {bcd[4*DIGITS-1:0], bin[BIN_W-1:0]}. Iteration counter is clog2(BIN_W+1) bits.
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE).
- IDLE:
  - On in_valid & in_ready, capture in_bcd into bcd and clear bin.
  - If any nibble of in_bcd is greater than 9: set out_binary=0, set err=1, go to DONE.
  - Otherwise: clear err, clear counter, go to SHIFT.
- SHIFT (one iteration per cycle):
  - Shift the whole {bcd,bin} register right by 1; the bcd LSB moves into the bin MSB.
  - After the shift, for every BCD digit with value >= 8, subtract 3 from that digit. All digits are corrected in parallel.
  - Increment the counter. After the BIN_W-th iteration, load out_binary from bin and go to DONE.
- DONE:
  - out_valid=1. out_binary and out_err are held stable while out_valid=1 and out_ready=0.
  - On out_ready, go to IDLE. in_ready rises on the next cycle; there is no same-cycle accept/deliver overlap.
- Latency, counted from the accept edge:
  - Valid operand: out_valid is first high in the cycle after BIN_W SHIFT cycles, i.e. BIN_W+1 edges after accept.
  - Invalid operand: 1 edge.
- Throughput: at most one conversion per BIN_W+2 cycles when out_ready is tied high.
- in_bcd is sampled only at accept; changes afterwards are ignored.
- in_valid while busy is ignored. The operand is not lost, because the producer holds it until in_ready.
- out_binary keeps its last value when out_valid=0. Only the value under out_valid is meaningful.
- Boundaries:
  - BCD 0 -> 0.
  - All-nines -> 10^DIGITS - 1, e.g. 999 -> 10'h3E7.
  - No overflow is possible given the BIN_W constraint.

Decomposition:
- Package bcd_pkg:
  - state encoding constants IDLE/SHIFT/DONE.
  - BCD_NIBBLE_W=4, BCD_MAX_DIGIT=9, ADJ_THRESH=8, ADJ_SUB=3.
  - The same constants are shared with binary2bcd_double_dabble (ADJ_THRESH there is 5, add 3).
- Sub-module bcd_digit_adjust:
  - Combinational, one nibble in and one out; outputs d-3 when d>=8, else d.
  - Instantiated DIGITS times by generate.

Test Plan:
1. Reset check: rst high for 2 cycles -> in_ready=1, out_valid=0, out_binary=0, out_err=0.
2. Basic conversion: in_bcd=12'h255, out_ready=1 -> out_valid asserted exactly 11 edges after accept, out_binary=255, out_err=0.
3. Sweep: all BCD 0..999 back-to-back, out_ready=1 -> every out_binary equals the decimal value. Also a round trip through binary2bcd_double_dabble for 0..255 matches the original.
4. Backpressure: in_bcd=12'h999 with out_ready=0 for 20 cycles, then 1 -> out_binary=999 stable throughout; in_ready=0 until the cycle after the out_ready handshake.
5. Invalid digit: in_bcd=12'h1A3 -> out_valid 1 edge after accept, out_err=1, out_binary=0. Next operand 12'h042 -> 42, out_err=0.
6. Reset mid-operation: accept 12'h500, assert rst at SHIFT iteration 4 -> no out_valid. Next operand 12'h007 -> 7.
